// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - two-read one-write register file, x0 hardwired to zero, write-first bypass
module regfile_2r1w #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [WIDTH-1:0]  rs1_data,
  output logic [WIDTH-1:0]  rs2_data
);

  // The address space is rounded up to a power of two; indices at or above
  // DEPTH, and index 0, are not real storage.
  localparam int NREG = 1 << ADDR_W;

  // One bit per address: set only for writable registers 1..DEPTH-1, so a
  // single lookup covers both the x0 rule and out-of-range addresses.
  localparam logic [NREG-1:0] VALID =
    ({NREG{1'b1}} >> (NREG - DEPTH)) & ~{{(NREG-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] regs [NREG];

  // Storage: asynchronous clear, otherwise a single write per edge to a valid index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en && VALID[wr_addr]) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Read mux shared by both ports: zero in reset or for invalid indices,
  // and the in-flight write data when it targets the same register.
  function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_W-1:0] a);
    logic [WIDTH-1:0] r;
    r = '0;
    if (rst && VALID[a]) begin
      if (wr_en && (a == wr_addr)) begin
        r = wr_data;
      end else begin
        r = regs[a];
      end
    end
    return r;
  endfunction

  // Read port 1: combinational, no clock latency.
  always_comb begin
    rs1_data = read_port(rs1_addr);
  end

  // Read port 2: independent of port 1 but using the same rules.
  always_comb begin
    rs2_data = read_port(rs2_addr);
  end

endmodule

// File: tb/tb_regfile_2r1w.sv
// tb/tb_regfile_2r1w.sv - directed self-checking bench for regfile_2r1w
module tb_regfile_2r1w;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [32];

  regfile_2r1w #(.WIDTH(32), .DEPTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data)
  );

  // 20 ns period: the negedge is exactly 10 ns after each posedge.
  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "timeout");
  end

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    if (a != 5'd0) model[a] = d;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    wr_en = 1'b0;
    wr_addr = 5'd0;
    wr_data = 32'h0;
    rs1_addr = 5'd0;
    rs2_addr = 5'd5;
    clear_model();
    #1;
    checks++;
    if (rs1_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_rs1: got %h expected %h", rs1_data, 32'h0);
    end
    checks++;
    if (rs2_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_rs2: got %h expected %h", rs2_data, 32'h0);
    end
    wr_en = 1'b1;
    wr_addr = 5'd4;
    wr_data = 32'h4444_4444;
    rs1_addr = 5'd4;
    #1;
    checks++;
    if (rs1_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_no_bypass: got %h expected %h", rs1_data, 32'h0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (rs1_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_write_ignored_edge: got %h expected %h", rs1_data, 32'h0);
    end
    @(negedge clk);
    wr_en = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (rs1_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_write_ignored_after: got %h expected %h", rs1_data, 32'h0);
    end
  endtask

  task automatic test_basic();
    do_write(5'd5, 32'hDEAD_BEEF);
    do_write(5'd31, 32'h1234_5678);
    rs1_addr = 5'd5;
    rs2_addr = 5'd31;
    #1;
    checks++;
    if (rs1_data !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL basic_rs1_x5: got %h expected %h", rs1_data, 32'hDEAD_BEEF);
    end
    checks++;
    if (rs2_data !== 32'h1234_5678) begin
      errors++;
      $display("FAIL basic_rs2_x31: got %h expected %h", rs2_data, 32'h1234_5678);
    end
  endtask

  task automatic test_x0();
    @(negedge clk);
    wr_en = 1'b1;
    wr_addr = 5'd0;
    wr_data = 32'hFFFF_FFFF;
    rs1_addr = 5'd0;
    rs2_addr = 5'd0;
    #1;
    checks++;
    if (rs1_data !== 32'h0) begin
      errors++;
      $display("FAIL x0_no_bypass: got %h expected %h", rs1_data, 32'h0);
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    #1;
    checks++;
    if (rs1_data !== 32'h0) begin
      errors++;
      $display("FAIL x0_rs1: got %h expected %h", rs1_data, 32'h0);
    end
    checks++;
    if (rs2_data !== 32'h0) begin
      errors++;
      $display("FAIL x0_rs2: got %h expected %h", rs2_data, 32'h0);
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    wr_en = 1'b1;
    wr_addr = 5'd7;
    wr_data = 32'hA5A5_A5A5;
    rs1_addr = 5'd7;
    rs2_addr = 5'd7;
    #1;
    checks++;
    if (rs1_data !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL bypass_rs1: got %h expected %h", rs1_data, 32'hA5A5_A5A5);
    end
    checks++;
    if (rs2_data !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL bypass_rs2: got %h expected %h", rs2_data, 32'hA5A5_A5A5);
    end
    rs2_addr = 5'd5;
    #1;
    checks++;
    if (rs2_data !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL bypass_other_port: got %h expected %h", rs2_data, 32'hDEAD_BEEF);
    end
    checks++;
    if (rs1_data !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL bypass_rs1_alone: got %h expected %h", rs1_data, 32'hA5A5_A5A5);
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    model[7] = 32'hA5A5_A5A5;
    #1;
    checks++;
    if (rs1_data !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL bypass_stored: got %h expected %h", rs1_data, 32'hA5A5_A5A5);
    end
  endtask

  task automatic test_same_reg();
    rs1_addr = 5'd31;
    rs2_addr = 5'd31;
    #1;
    checks++;
    if (rs1_data !== 32'h1234_5678 || rs2_data !== 32'h1234_5678) begin
      errors++;
      $display("FAIL same_reg: got %h/%h expected %h", rs1_data, rs2_data, 32'h1234_5678);
    end
  endtask

  task automatic test_hold();
    do_write(5'd3, 32'h1);
    @(negedge clk);
    wr_en = 1'b0;
    wr_addr = 5'd3;
    wr_data = 32'hFFFF;
    rs1_addr = 5'd3;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (rs1_data !== 32'h1) begin
        errors++;
        $display("FAIL hold_x3_cycle%0d: got %h expected %h", c, rs1_data, 32'h1);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 1; i < 32; i++) do_write(5'(i), 32'h100 + 32'(i));
    @(negedge clk);
    rs1_addr = 5'd1;
    rs2_addr = 5'd31;
    #1;
    checks++;
    if (rs1_data !== 32'h101 || rs2_data !== 32'h11F) begin
      errors++;
      $display("FAIL fill_readback: got %h/%h expected %h/%h", rs1_data, rs2_data, 32'h101, 32'h11F);
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
    clear_model();
    #1;
    checks++;
    if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
      errors++;
      $display("FAIL async_clear_immediate: got %h/%h expected 0/0", rs1_data, rs2_data);
    end
    rst = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i);
      rs2_addr = 5'(31 - i);
      #1;
      checks++;
      if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
        errors++;
        $display("FAIL after_release_addr%0d: got %h/%h expected 0/0", i, rs1_data, rs2_data);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    @(negedge clk);
    wr_en = 1'b1;
    wr_addr = 5'd9;
    wr_data = 32'h0000_0099;
    rs1_addr = 5'd9;
    #1;
    checks++;
    if (rs1_data !== 32'h99) begin
      errors++;
      $display("FAIL midwrite_bypass: got %h expected %h", rs1_data, 32'h99);
    end
    #4;
    rst = 1'b0;
    clear_model();
    #1;
    checks++;
    if (rs1_data !== 32'h0) begin
      errors++;
      $display("FAIL midwrite_bypass_off: got %h expected %h", rs1_data, 32'h0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (rs1_data !== 32'h0) begin
      errors++;
      $display("FAIL midwrite_reset_wins: got %h expected %h", rs1_data, 32'h0);
    end
    @(negedge clk);
    rst = 1'b1;
    wr_data = 32'h0000_0077;
    #1;
    checks++;
    if (rs1_data !== 32'h77) begin
      errors++;
      $display("FAIL release_bypass: got %h expected %h", rs1_data, 32'h77);
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    model[9] = 32'h77;
    #1;
    checks++;
    if (rs1_data !== 32'h77) begin
      errors++;
      $display("FAIL release_first_write: got %h expected %h", rs1_data, 32'h77);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp1;
    logic [31:0] exp2;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      exp1 = (wr_en && wr_addr != 5'd0 && rs1_addr == wr_addr) ? wr_data : model[rs1_addr];
      exp2 = (wr_en && wr_addr != 5'd0 && rs2_addr == wr_addr) ? wr_data : model[rs2_addr];
      checks++;
      if (rs1_data !== exp1 || rs2_data !== exp2) begin
        errors++;
        $display("FAIL random_post_edge_c%0d: got %h/%h expected %h/%h", c, rs1_data, rs2_data, exp1, exp2);
      end
      wr_en = ((c / 5) % 2) == 0;
      wr_addr = 5'($urandom_range(0, 31));
      wr_data = $urandom;
      rs1_addr = (c % 3 == 0) ? wr_addr : 5'($urandom_range(0, 31));
      rs2_addr = (c % 4 == 0) ? wr_addr : 5'($urandom_range(0, 31));
      #1;
      exp1 = (wr_en && wr_addr != 5'd0 && rs1_addr == wr_addr) ? wr_data : model[rs1_addr];
      exp2 = (wr_en && wr_addr != 5'd0 && rs2_addr == wr_addr) ? wr_data : model[rs2_addr];
      checks++;
      if (rs1_data !== exp1 || rs2_data !== exp2) begin
        errors++;
        $display("FAIL random_comb_c%0d: got %h/%h expected %h/%h", c, rs1_data, rs2_data, exp1, exp2);
      end
      @(posedge clk);
      if (wr_en && wr_addr != 5'd0) model[wr_addr] = wr_data;
    end
    @(negedge clk);
    wr_en = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i);
      rs2_addr = 5'(i);
      #1;
      checks++;
      if (rs1_data !== model[i] || rs2_data !== model[i]) begin
        errors++;
        $display("FAIL random_sweep_x%0d: got %h/%h expected %h", i, rs1_data, rs2_data, model[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_x0();
    test_bypass();
    test_same_reg();
    test_hold();
    test_async_reset();
    test_reset_mid_write();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_2r1w.md
REGFILE_2R1W -- requirements
Module: regfile_2r1w

Interface
REQ-001: Parameter WIDTH, default 32, data width of each register in bits.
REQ-002: Parameter DEPTH, default 32, number of registers; address width is $clog2(DEPTH), 5 at default.
REQ-003: clk  input  1  single clock; all register state updates on posedge clk.
REQ-004: rst  input  1  reset, asynchronous, active-low; rst=0 clears state immediately, independent of clk.
REQ-005: wr_en  input  1  write enable, sampled at posedge clk.
REQ-006: wr_addr  input  ADDR_W  destination register index.
REQ-007: wr_data  input  WIDTH  write data.
REQ-008: rs1_addr  input  ADDR_W  read port 1 index.
REQ-009: rs2_addr  input  ADDR_W  read port 2 index.
REQ-010: rs1_data  output  WIDTH  read port 1 data, combinational.
REQ-011: rs2_data  output  WIDTH  read port 2 data, combinational.

Function
REQ-012: The block SHALL hold DEPTH registers of WIDTH bits, with one write port and two independent read ports.
REQ-013: On posedge clk with rst=1, wr_en=1 and wr_addr!=0, the block SHALL load wr_data into register[wr_addr].
REQ-014: With wr_en=0, every register SHALL hold its value across clock edges.
REQ-015: Register 0 SHALL read as all zeros at all times; writes to address 0 SHALL be discarded without error.
REQ-016: Each read port SHALL output register[rsN_addr] combinationally, with no clock latency.
REQ-017: Write-to-read bypass: when wr_en=1, wr_addr!=0 and rsN_addr==wr_addr, rsN_data SHALL equal wr_data in that same cycle (write-first).
REQ-018: Bypass SHALL apply to each read port independently; both ports reading wr_addr SHALL both return wr_data.
REQ-019: Both read ports addressing the same register SHALL return identical data.
REQ-020: X or out-of-range addresses (DEPTH not a power of 2) SHALL read as zero and SHALL NOT corrupt any register on write.
REQ-021: Only one register SHALL change per clock edge; no other register is disturbed by a write.

Reset
REQ-022: rst=0 SHALL asynchronously clear every register to 0, within the same time step and without a clock edge.
REQ-023: While rst=0, writes SHALL be ignored, rs1_data and rs2_data SHALL read 0, and bypass SHALL be disabled.
REQ-024: Reset asserted in the middle of a write cycle SHALL take priority; the register ends at 0.
REQ-025: After rst returns to 1, the first posedge clk with wr_en=1 SHALL write normally; reset deassertion requires no extra cycles.

Verification
REQ-026: Write 0xDEADBEEF to x5 and 0x12345678 to x31 on two edges, then rs1=5 and rs2=31 -> rs1_data=0xDEADBEEF and rs2_data=0x12345678.
REQ-027: Write 0xFFFFFFFF to x0, then rs1=0 and rs2=0 -> both outputs 0x00000000.
REQ-028: wr_en=1, wr_addr=7, wr_data=0xA5A5A5A5, with rs1=7 and rs2=7 in the same cycle -> both outputs 0xA5A5A5A5 before the clock edge.
REQ-029: Fill x1..x31 with 0x100+i, then drive rst=0 mid-cycle with no clock edge -> all reads return 0 immediately; after release, reads stay 0 until written.
REQ-030: wr_en toggles 5 cycles on and 5 cycles off with random wr_data and wr_addr -> register contents match a golden array model every cycle, with outputs checked 10 ns after posedge.
REQ-031: Write 0x1 to x3, then hold wr_en=0 and drive wr_data=0xFFFF for 10 cycles -> x3 reads 0x1 throughout.
